// File: rtl/game_flow_if.sv
// Handshake/status bundle between the round sequencer and the rest of the game.
// master drives player/video inputs; slave is the sequencer itself.
interface game_flow_if;
    logic        start;
    logic        ack;
    logic [15:0] score;
    logic        ghost_hit;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        move_en;
    logic        sprite_reset;
    logic        frame_start;
    logic        playing;
    logic [1:0]  lives;
    logic        win;
    logic        lose;
    logic [2:0]  state;

    modport master (
        output start, ack, score, ghost_hit, hCount, vCount,
        input  move_en, sprite_reset, frame_start, playing,
        input  lives, win, lose, state
    );

    modport slave (
        input  start, ack, score, ghost_hit, hCount, vCount,
        output move_en, sprite_reset, frame_start, playing,
        output lives, win, lose, state
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Round sequencer: idle/play/dying/won/lost FSM, movement tick,
// sprite-reset and frame-start pulses, and lives bookkeeping.
module game_flow_ctrl #(
    parameter int unsigned TICK_DIV     = 10000,
    parameter int unsigned WIN_SCORE    = 30,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned DEATH_CYCLES = 25000000
) (
    input logic        clk,
    input logic        reset,
    game_flow_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DYING = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } state_t;

    localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
    localparam logic [31:0] DEATH_LAST = 32'(DEATH_CYCLES - 1);
    localparam logic [15:0] WIN_TH     = 16'(WIN_SCORE);
    localparam logic [1:0]  LIVES0     = 2'(LIVES_INIT);

    state_t      st, nst;
    logic [31:0] tick_cnt, tick_d;
    logic [31:0] death_cnt, death_d;
    logic [1:0]  lives_q, lives_d;
    logic        move_q, move_d;
    logic        srst_q, srst_d;
    logic        frame_q, frame_d;
    logic        play_q, win_q, lose_q;
    logic        win_hit, death_done;

    assign win_hit    = (bus.score >= WIN_TH);
    assign death_done = (death_cnt == DEATH_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= nst;
    end

    // Win outranks a same-cycle ghost hit, so lives stay intact on a win.
    always_comb begin
        nst = st;
        unique case (st)
            IDLE:  if (bus.start) nst = PLAY;
            PLAY: begin
                if (win_hit)            nst = WON;
                else if (bus.ghost_hit) nst = DYING;
            end
            DYING: if (death_done) nst = (lives_q == 2'd0) ? LOST : PLAY;
            WON:   if (bus.ack) nst = IDLE;
            LOST:  if (bus.ack) nst = IDLE;
            default: nst = IDLE;
        endcase
    end

    always_comb begin
        tick_d  = tick_cnt;
        death_d = death_cnt;
        lives_d = lives_q;
        move_d  = 1'b0;
        srst_d  = 1'b0;
        frame_d = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);
        unique case (st)
            IDLE: begin
                if (nst == PLAY) begin
                    srst_d  = 1'b1;
                    tick_d  = 32'd0;
                    lives_d = LIVES0;
                end
            end
            PLAY: begin
                // The tick only fires while the round keeps playing.
                if (nst == PLAY) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_d = 32'd0;
                        move_d = 1'b1;
                    end else begin
                        tick_d = tick_cnt + 32'd1;
                    end
                end else if (nst == DYING) begin
                    death_d = 32'd0;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end
            end
            DYING: begin
                death_d = death_cnt + 32'd1;
                if (nst == PLAY) begin
                    srst_d = 1'b1;
                    tick_d = 32'd0;
                end
            end
            WON:  if (nst == IDLE) lives_d = LIVES0;
            LOST: if (nst == IDLE) lives_d = LIVES0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= 32'd0;
            death_cnt <= 32'd0;
            lives_q   <= LIVES0;
            move_q    <= 1'b0;
            srst_q    <= 1'b0;
            frame_q   <= 1'b0;
            play_q    <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            tick_cnt  <= tick_d;
            death_cnt <= death_d;
            lives_q   <= lives_d;
            move_q    <= move_d;
            srst_q    <= srst_d;
            frame_q   <= frame_d;
            play_q    <= (nst == PLAY);
            win_q     <= (nst == WON);
            lose_q    <= (nst == LOST);
        end
    end

    assign bus.move_en      = move_q;
    assign bus.sprite_reset = srst_q;
    assign bus.frame_start  = frame_q;
    assign bus.playing      = play_q;
    assign bus.lives        = lives_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
    assign bus.state        = st;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level sequencer for one game round.
- Runs the round state machine: idle, play, death pause, win, lose.
- Generates the single-cycle movement-tick enable that paces sprite movement, and the sprite-reset pulse that returns sprites to spawn.
- Generates a frame-start pulse that clears per-frame wall-probe flags in the movement blocks.
- Tracks remaining lives; drives the win/lose indications consumed by the display overlay.

Parameters:
- TICK_DIV, 10000: clk cycles per movement tick; legal range 2..2^32-1.
- WIN_SCORE, 30: score value at or above which the round is won.
- LIVES_INIT, 3: lives at round start; legal range 1..3.
- DEATH_CYCLES, 25000000: length of the death pause in clk cycles; legal range ≥ 1.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain)
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begins a round when sampled high in IDLE
- ack  in  1  level; acknowledges win/lose when sampled high in WON/LOST
- score  in  16  current score, unsigned, synchronous to clk
- ghost_hit  in  1  level; pacman/ghost overlap this cycle
- hCount  in  10  VGA horizontal counter
- vCount  in  10  VGA vertical counter
- move_en  out  1  one-cycle movement tick; high only in PLAY
- sprite_reset  out  1  one-cycle pulse; sprites return to spawn
- frame_start  out  1  one-cycle pulse when hCount==0 && vCount==0, in every state
- playing  out  1  high while state == PLAY
- lives  out  2  remaining lives
- win  out  1  high while state == WON
- lose  out  1  high while state == LOST
- state  out  3  encoding: IDLE=0, PLAY=1, DYING=2, WON=3, LOST=4

Behaviour:
- Reset (asynchronous): state=IDLE, lives=LIVES_INIT, tick_cnt=0, death_cnt=0. All pulse outputs 0; win=0, lose=0, playing=0.
- Reset mid-round: abandons the round immediately, with no sprite_reset pulse.
- All outputs are registered; state changes are visible the cycle after the triggering input is sampled.
- IDLE:
  - start=1 → PLAY.
  - sprite_reset=1 for exactly the first PLAY cycle; tick_cnt=0; lives=LIVES_INIT.
  - ack, ghost_hit and score are ignored.
- PLAY:
  - tick_cnt increments every cycle.
  - When tick_cnt==TICK_DIV-1: move_en=1 on the next cycle and tick_cnt returns to 0. First move_en is TICK_DIV cycles after entering PLAY; period is exactly TICK_DIV.
  - Checks in priority order:
    - (a) score >= WIN_SCORE → WON.
    - (b) ghost_hit → DYING, lives decremented by 1 (saturates at 0), death_cnt=0.
    - Simultaneous score threshold and ghost_hit → WON; lives unchanged.
  - start ignored.
- DYING:
  - move_en held 0; death_cnt increments.
  - When death_cnt==DEATH_CYCLES-1:
    - lives==0 → LOST.
    - Otherwise → PLAY, with sprite_reset pulse and tick_cnt=0.
  - ghost_hit and score ignored; ghost_hit must not re-decrement lives.
- WON / LOST:
  - win or lose held high.
  - ack=1 → IDLE, lives=LIVES_INIT.
  - start is ignored. If both start and ack are high, the FSM goes to IDLE and then to PLAY on the next cycle only if start is still high.
- move_en, sprite_reset and frame_start never stay high longer than 1 cycle.
- sprite_reset and move_en never coincide.
- Counters: tick_cnt and death_cnt are 32-bit, no wrap in normal use. Score compare is 16-bit unsigned.
- playing, win and lose are mutually exclusive.

Test Plan:
- Reset, hold start=1 one cycle (TICK_DIV=4):
  - sprite_reset=1 in the first PLAY cycle.
  - move_en pulses at cycles 4, 8, 12 after PLAY entry.
  - playing=1, lives=3.
- PLAY, pulse ghost_hit (DEATH_CYCLES=10):
  - state=DYING, lives=2, move_en=0 for 10 cycles.
  - Return to PLAY with one sprite_reset pulse; ghost_hit held high during DYING leaves lives=2.
- Three ghost_hits with LIVES_INIT=3:
  - After third DYING, state=LOST, lose=1.
  - ack=1 → IDLE, lives=3, lose=0.
- score driven 29→30 in PLAY:
  - WON, win=1, move_en stops.
  - Same-cycle score=30 and ghost_hit → WON with lives unchanged.
- Assert reset mid-DYING and mid-WON:
  - Immediately IDLE, lives=3, all outputs 0.
  - start then resumes normally.
- Sweep hCount/vCount through a full 800x525 frame in IDLE and PLAY:
  - Exactly one frame_start pulse per frame, at (0,0).
